// File: rtl/uart_bus_bridge.sv
// ASCII-hex UART-to-bus master: L/W/C/R commands drive a cs/we/ack bus, and read data
// goes back to the UART as lower-case hex. Covers multi-digit words, burst reads and a bus timeout.
module uart_bus_bridge #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_cs,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_dat,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_ack,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_dat,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_dat,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [2:0]        dbg_state
);
  // Handshakes: a tx byte transfers on any edge where o_tx_valid && i_tx_ready.
  // o_tx_valid and o_tx_dat hold until then. An rx byte is a one-cycle i_rx_valid pulse
  // with no back-pressure, and a bus cycle completes on the edge where o_cs && i_ack.
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, CNT, WBUS, RBUS, TXHEX, TXERR} state_t;

  localparam int A_DIG = ADDR_W / 4;
  localparam int D_DIG = DATA_W / 4;
  localparam int MX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int SH_W  = (MX_W > 8) ? MX_W : 8;
  localparam int DC_W  = $clog2(SH_W / 4 + 1);
  localparam int NC_W  = (D_DIG > 1) ? $clog2(D_DIG) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NC_W-1:0] NC_LAST = NC_W'(D_DIG - 1);

  state_t            state;
  logic [SH_W-1:0]   shadow;
  logic [SH_W-1:0]   shifted;
  logic [DC_W-1:0]   dcnt;
  logic [DC_W-1:0]   dig_tgt;
  logic [7:0]        cnt;
  logic [7:0]        left;
  logic [TO_W-1:0]   tcnt;
  logic [DATA_W-1:0] rdata;
  logic [NC_W-1:0]   nidx;
  logic [4:0]        dec;
  logic              rx;
  logic              is_cmd;
  logic              dig_last;

  // Returns {valid, nibble}; accepts 0-9, a-f and A-F.
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) return {1'b1, c[3:0] + 4'd9};
    else return 5'd0;
  endfunction

  function automatic logic [7:0] hex_enc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  assign o_busy    = !(state inside {IDLE, ADDR, WDATA, CNT});
  assign dbg_state = state;

  always_comb begin
    dec      = hex_dec(i_rx_dat);
    shifted  = {shadow[SH_W-5:0], dec[3:0]};
    rx       = i_rx_valid && !o_busy;
    is_cmd   = i_rx_dat inside {8'h4c, 8'h57, 8'h43, 8'h52};
    dig_tgt  = DC_W'(1);
    if (state == ADDR) dig_tgt = DC_W'(A_DIG - 1);
    else if (state == WDATA) dig_tgt = DC_W'(D_DIG - 1);
    dig_last = (dcnt == dig_tgt);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      o_cs       <= 1'b0;
      o_we       <= 1'b0;
      o_addr     <= '0;
      o_dat      <= '0;
      o_tx_valid <= 1'b0;
      o_tx_dat   <= '0;
      o_overrun  <= 1'b0;
      shadow     <= '0;
      dcnt       <= '0;
      cnt        <= '0;
      left       <= '0;
      tcnt       <= '0;
      rdata      <= '0;
      nidx       <= '0;
    end else begin
      if (i_rx_valid && o_busy) o_overrun <= 1'b1;
      case (state)
        IDLE, ADDR, WDATA, CNT: begin
          if (rx) begin
            if (is_cmd) begin
              shadow <= '0;
              dcnt   <= '0;
              case (i_rx_dat)
                8'h4c:   state <= ADDR;
                8'h57:   state <= WDATA;
                8'h43:   state <= CNT;
                default: begin
                  state <= RBUS;
                  o_cs  <= 1'b1;
                  o_we  <= 1'b0;
                  tcnt  <= '0;
                  left  <= cnt;
                end
              endcase
            end else if (!dec[4]) begin
              state      <= TXERR;
              dcnt       <= '0;
              o_tx_valid <= 1'b1;
              o_tx_dat   <= 8'h3f;
            end else if (state != IDLE) begin
              // Digits in IDLE belong to no command and are ignored.
              shadow <= shifted;
              if (!dig_last) begin
                dcnt <= dcnt + DC_W'(1);
              end else begin
                dcnt <= '0;
                case (state)
                  ADDR: begin
                    o_addr <= shifted[ADDR_W-1:0];
                    state  <= IDLE;
                  end
                  CNT: begin
                    cnt   <= shifted[7:0];
                    state <= IDLE;
                  end
                  default: begin
                    o_dat <= shifted[DATA_W-1:0];
                    o_cs  <= 1'b1;
                    o_we  <= 1'b1;
                    tcnt  <= '0;
                    state <= WBUS;
                  end
                endcase
              end
            end
          end
        end
        WBUS, RBUS: begin
          if (i_ack) begin
            o_cs   <= 1'b0;
            o_we   <= 1'b0;
            o_addr <= o_addr + ADDR_W'(1);
            if (state == WBUS) begin
              state <= WDATA;
              dcnt  <= '0;
            end else begin
              state      <= TXHEX;
              rdata      <= i_dat << 4;
              nidx       <= '0;
              o_tx_valid <= 1'b1;
              o_tx_dat   <= hex_enc(i_dat[DATA_W-1 -: 4]);
            end
          end else if (TIMEOUT != 0 && tcnt == TO_LAST) begin
            o_cs       <= 1'b0;
            o_we       <= 1'b0;
            state      <= TXERR;
            o_tx_valid <= 1'b1;
            o_tx_dat   <= 8'h21;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        TXHEX: begin
          if (i_tx_ready) begin
            if (nidx == NC_LAST) begin
              o_tx_valid <= 1'b0;
              if (left == 8'd0) begin
                state <= IDLE;
              end else begin
                left  <= left - 8'd1;
                state <= RBUS;
                o_cs  <= 1'b1;
                o_we  <= 1'b0;
                tcnt  <= '0;
              end
            end else begin
              nidx     <= nidx + NC_W'(1);
              o_tx_dat <= hex_enc(rdata[DATA_W-1 -: 4]);
              rdata    <= rdata << 4;
            end
          end
        end
        TXERR: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: scripted command strings, a memory responder,
// and expected queues for transmitted characters and bus writes.
module tb_uart_bus_bridge;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cs, we, ack = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dat, rd_dat = '0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_dat = 8'h00;
  logic              tx_valid, tx_ready = 1'b1;
  logic [7:0]        tx_dat;
  logic              busy, overrun;
  logic [2:0]        dbg_state;

  logic [7:0]  exp_q[$];
  logic [23:0] wexp_q[$];
  logic [7:0]  mem [0:65535];
  int          checks = 0;
  int          failures = 0;
  int          cs_cycles = 0;
  int          ready_mode = 0;
  bit          ack_en = 1'b1;
  bit          pend = 1'b0;
  bit          rst_at_edge = 1'b1;
  logic [7:0]  pend_dat = 8'h00;

  uart_bus_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .o_cs(cs), .o_we(we), .o_addr(addr), .o_dat(dat),
    .i_dat(rd_dat), .i_ack(ack), .i_rx_valid(rx_valid), .i_rx_dat(rx_dat),
    .o_tx_valid(tx_valid), .o_tx_dat(tx_dat), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_overrun(overrun), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  always @(posedge clk) rst_at_edge = reset;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // UART sink, memory responder and scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'b0;
    endcase
    if (pend && !rst_at_edge) check("tx_hold", {23'd0, tx_valid, tx_dat}, {23'd0, 1'b1, pend_dat});
    pend     = tx_valid && !tx_ready;
    pend_dat = tx_dat;
    if (tx_valid && tx_ready && !reset) begin
      if (exp_q.size() == 0) check("tx_extra", 32'(tx_dat), 32'h100);
      else check("tx_char", 32'(tx_dat), 32'(exp_q.pop_front()));
    end
    if (ack) begin
      ack = 1'b0;
    end else if (cs && ack_en && !reset) begin
      ack    = 1'b1;
      rd_dat = mem[addr];
      if (we) begin
        if (wexp_q.size() == 0) check("wr_extra", {8'd0, addr, dat}, 32'hffff_ffff);
        else check("wr", {8'd0, addr, dat}, {8'd0, wexp_q.pop_front()});
        mem[addr] = dat;
      end
    end
    if (cs) cs_cycles++;
  end

  // Driver tasks; all start and end on a falling edge.
  task automatic send_byte(input logic [7:0] c);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rx_wait", 32'(busy), 32'd0);
    rx_valid = 1'b1;
    rx_dat   = c;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic push_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size() + wexp_q.size()) + 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, 32'(cs), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_dat"}, 32'(dat), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_dat"}, 32'(tx_dat), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int n;
    mem[16'h12ff] = 8'hab;
    mem[16'h1300] = 8'h05;
    mem[16'hffff] = 8'h11;
    mem[16'h0000] = 8'h22;
    mem[16'h0011] = 8'h7e;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // Two consecutive writes from one W command
    wexp_q.push_back({16'h1a00, 8'h4d});
    wexp_q.push_back({16'h1a01, 8'h00});
    send_str("L1a00W4d00");
    wait_done("t1_done");
    check("t1_addr", 32'(addr), 32'h1a02);

    // Burst read of two words under a toggling tx_ready
    ready_mode = 1;
    push_exp("ab05");
    send_str("L12FFC01R");
    wait_done("t2_done");
    ready_mode = 0;
    check("t2_addr", 32'(addr), 32'h1301);

    // Address wraps from ffff to 0
    push_exp("11");
    send_str("C00LffffR");
    wait_done("t3a_done");
    check("t3_wrap_addr", 32'(addr), 32'h0000);
    push_exp("22");
    send_str("R");
    wait_done("t3b_done");
    check("t3_addr", 32'(addr), 32'h0001);

    // No ack: cs lasts TIMEOUT cycles, then '!'
    ack_en = 1'b0;
    cs_cycles = 0;
    push_exp("!");
    send_str("L0010R");
    wait_done("t4_done");
    check("t4_cs_cycles", 32'(cs_cycles), 32'd8);
    check("t4_addr", 32'(addr), 32'h0010);
    ack_en = 1'b1;

    // Bad character, then an aborted address group followed by a write
    push_exp("?");
    send_str("L12x");
    wait_done("t5a_done");
    check("t5_addr_kept", 32'(addr), 32'h0010);
    check("t5_state", 32'(dbg_state), 32'd0);
    wexp_q.push_back({16'h0010, 8'h3c});
    send_str("L12W3c");
    wait_done("t5b_done");
    check("t5_addr", 32'(addr), 32'h0011);

    // Byte arriving during a bus read sets overrun and is dropped
    ack_en = 1'b0;
    push_exp("!");
    send_str("R");
    check("t6_busy", 32'(busy), 32'd1);
    rx_valid = 1'b1;
    rx_dat   = 8'h4c;
    @(negedge clk);
    rx_valid = 1'b0;
    check("t6_overrun", 32'(overrun), 32'd1);
    wait_done("t6a_done");
    check("t6_addr", 32'(addr), 32'h0011);
    check("t6_state", 32'(dbg_state), 32'd0);
    ack_en = 1'b1;

    // Reset in the middle of sending hex
    ready_mode = 2;
    send_str("R");
    n = 0;
    while (dbg_state != 3'd6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_txhex", 32'(dbg_state), 32'd6);
    check("t6_tx_valid", 32'(tx_valid), 32'd1);
    check("t6_tx_dat", 32'(tx_dat), 32'h37);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("t6_rst");
    reset = 1'b0;
    ready_mode = 0;
    repeat (20) @(negedge clk);
    check("t6_no_resume_tx", 32'(tx_valid), 32'd0);
    check("t6_no_resume_cs", 32'(cs), 32'd0);
    check("t6_idle", 32'(dbg_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
